// File: rtl/mul_div_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op codes and
// sequencer state encodings.
package mul_div_sequencer_pkg;

  localparam int unsigned ALU_OP_W = 4;

  // ALU op select codes understood by the shared datapath ALU
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Bundle between the multiply/divide sequencer and its environment:
// start/operand request, shared-ALU operands and result, and HI/LO result.
//   slave  : the sequencer side
//   master : controller + ALU side
interface mul_div_sequencer_if #(
  parameter int unsigned N = 32
);
  logic                                       start;
  logic                                       is_div;
  logic [N-1:0]                               opa;
  logic [N-1:0]                               opb;
  logic [mul_div_sequencer_pkg::ALU_OP_W-1:0] alu_op;
  logic [N-1:0]                               alu_a;
  logic [N-1:0]                               alu_b;
  logic [N-1:0]                               alu_result;
  logic                                       alu_cout;
  logic                                       busy;
  logic                                       done;
  logic [N-1:0]                               hi;
  logic [N-1:0]                               lo;

  modport slave (
    input  start, is_div, opa, opb, alu_result, alu_cout,
    output alu_op, alu_a, alu_b, busy, done, hi, lo
  );

  modport master (
    output start, is_div, opa, opb, alu_result, alu_cout,
    input  alu_op, alu_a, alu_b, busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_sequencer_mdu_step.sv
// One multiply or restoring-divide iteration: ALU operand selection and the
// next {hi, lo} computed from the shared ALU's result and carry/borrow.
// Purely combinational.
//   is_div     : 0 = shift-add multiply, 1 = restoring divide
//   hi, lo     : current accumulator / remainder and multiplier / quotient
//   operand    : multiplicand or divisor latched at start
//   alu_result, alu_cout : shared ALU outputs for the operands driven here
//   alu_*_c    : ALU op select and operands
//   hi_nxt_c, lo_nxt_c : values to register at the end of the iteration
module mdu_step
  import mul_div_sequencer_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                is_div,
  input  logic [N-1:0]        hi,
  input  logic [N-1:0]        lo,
  input  logic [N-1:0]        operand,
  input  logic [N-1:0]        alu_result,
  input  logic                alu_cout,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic [N-1:0]        alu_a_c,
  output logic [N-1:0]        alu_b_c,
  output logic [N-1:0]        hi_nxt_c,
  output logic [N-1:0]        lo_nxt_c
);

  // Partial remainder after shifting in the next dividend bit (low N bits)
  logic [N-1:0] t;
  assign t = {hi[N-2:0], lo[N-1]};

  always_comb begin
    alu_op_c = ALU_ADD;
    alu_a_c  = hi;
    alu_b_c  = '0;
    hi_nxt_c = hi;
    lo_nxt_c = lo;
    if (is_div) begin
      alu_op_c = ALU_SUB;
      alu_a_c  = t;
      alu_b_c  = operand;
      // A set shifted-out top bit means the true partial remainder is >= 2^N,
      // so the subtraction always fits regardless of the ALU borrow.
      if (hi[N-1] || !alu_cout) begin
        hi_nxt_c = alu_result;
        lo_nxt_c = {lo[N-2:0], 1'b1};
      end else begin
        hi_nxt_c = t;
        lo_nxt_c = {lo[N-2:0], 1'b0};
      end
    end else begin
      alu_b_c = lo[0] ? operand : '0;
      {hi_nxt_c, lo_nxt_c} = {alu_cout, alu_result, lo[N-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer. Drives the shared ALU for N
// iterations and produces HI/LO.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : start/is_div/opa/opb request, ALU op/operands out,
//                ALU result/carry in, busy/done status, hi/lo results
module mul_div_sequencer
  import mul_div_sequencer_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  mul_div_sequencer_if.slave bus
);

  mdu_state_e    state;
  logic [CW-1:0] counter;
  logic          is_div_q;
  logic [N-1:0]  opb_q;
  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;
  logic          busy_q;
  logic          done_q;

  logic [ALU_OP_W-1:0] step_op_c;
  logic [N-1:0]        step_a_c;
  logic [N-1:0]        step_b_c;
  logic [N-1:0]        hi_nxt_c;
  logic [N-1:0]        lo_nxt_c;

  mdu_step #(.N(N)) u_step (
    .is_div     (is_div_q),
    .hi         (hi_q),
    .lo         (lo_q),
    .operand    (opb_q),
    .alu_result (bus.alu_result),
    .alu_cout   (bus.alu_cout),
    .alu_op_c   (step_op_c),
    .alu_a_c    (step_a_c),
    .alu_b_c    (step_b_c),
    .hi_nxt_c   (hi_nxt_c),
    .lo_nxt_c   (lo_nxt_c)
  );

  // Sequencer FSM, iteration counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      counter  <= '0;
      is_div_q <= 1'b0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= ST_CALC;
            busy_q   <= 1'b1;
            is_div_q <= bus.is_div;
            opb_q    <= bus.opb;
            hi_q     <= '0;
            lo_q     <= bus.opa;
            counter  <= '0;
          end
        end
        ST_CALC: begin
          hi_q <= hi_nxt_c;
          lo_q <= lo_nxt_c;
          if (counter == CW'(N - 1)) begin
            state   <= ST_DONE;
            counter <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // ALU is only driven while iterating; otherwise it sees a benign add of zeros.
  // These decode registered state only, so there is no input-to-output path.
  assign bus.alu_op = (state == ST_CALC) ? step_op_c : ALU_ADD;
  assign bus.alu_a  = (state == ST_CALC) ? step_a_c  : '0;
  assign bus.alu_b  = (state == ST_CALC) ? step_b_c  : '0;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
module tb_mul_div_sequencer;

  localparam int unsigned N = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mul_div_sequencer_if #(.N(N)) bus ();

  mul_div_sequencer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: add reports carry out, sub reports borrow
  always_comb begin
    bus.alu_result = '0;
    bus.alu_cout   = 1'b0;
    case (bus.alu_op)
      4'b0010: {bus.alu_cout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'b0110: begin
        bus.alu_result = bus.alu_a - bus.alu_b;
        bus.alu_cout   = (bus.alu_a < bus.alu_b);
      end
      4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = '0;
    endcase
  end

  // Starts an op (start seen at edge 0) and checks cycles 1..34.
  // With inject set, extra start pulses are driven in cycles 5 and 20.
  task automatic run_op(input logic div, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo,
                        input bit inject, input string nm);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = div;
    bus.opa    = a;
    bus.opb    = b;
    @(negedge clk);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      checks++;
      if (bus.busy !== (cyc <= 32)) begin
        errors++;
        $display("FAIL %s busy cyc%0d: got %b want %b", nm, cyc, bus.busy, (cyc <= 32));
      end
      checks++;
      if (bus.done !== (cyc == 33)) begin
        errors++;
        $display("FAIL %s done cyc%0d: got %b want %b", nm, cyc, bus.done, (cyc == 33));
      end
      if (cyc == 1) begin
        checks++;
        if (bus.alu_op !== (div ? 4'b0110 : 4'b0010)) begin
          errors++;
          $display("FAIL %s alu_op: got %b want %b", nm, bus.alu_op, (div ? 4'b0110 : 4'b0010));
        end
      end
      if (cyc == 33) begin
        checks++;
        if (bus.hi !== exp_hi) begin
          errors++;
          $display("FAIL %s hi: got %h want %h", nm, bus.hi, exp_hi);
        end
        checks++;
        if (bus.lo !== exp_lo) begin
          errors++;
          $display("FAIL %s lo: got %h want %h", nm, bus.lo, exp_lo);
        end
      end
      if (inject && (cyc == 5 || cyc == 20)) begin
        bus.start  = 1'b1;
        bus.is_div = 1'b1;
        bus.opa    = 32'd99;
        bus.opb    = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got busy=%b done=%b want 0 0", nm, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.is_div = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset status: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset hilo: got %h %h want 0 0", bus.hi, bus.lo);
    end
    checks++;
    if (bus.alu_op !== 4'b0010 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
      errors++;
      $display("FAIL reset alu: got op=%b a=%h b=%h want 0010 0 0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_multu();
    run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'h0000002A, 1'b0, "mul7x6");
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "mulmax");
  endtask

  task automatic test_divu();
    run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div100_7");
    run_op(1'b1, 32'h80000000, 32'd1, 32'd0, 32'h80000000, 1'b0, "divtop");
    run_op(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, "div0");
  endtask

  task automatic test_busy_start_hold();
    run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, "busystart");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd12 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL hold idle%0d: got hi=%h lo=%h busy=%b done=%b want 0 c 0 0",
                 i, bus.hi, bus.lo, bus.busy, bus.done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = 1'b1;
    bus.opa    = 32'd100;
    bus.opb    = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    // cycle 10: reset together with a start that must be dropped
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midop busy before reset: got %b want 1", bus.busy);
    end
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.is_div = 1'b0;
    bus.opa    = 32'd9;
    bus.opb    = 32'd9;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midop status: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL midop hilo: got %h %h want 0 0", bus.hi, bus.lo);
    end
    checks++;
    if (dut.state !== 2'd0) begin
      errors++;
      $display("FAIL midop state: got %0d want 0", dut.state);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL midop dropped start: got busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
    end
    run_op(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, "mul2x2");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu();
    test_divu();
    test_busy_start_hold();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
